// File: rtl/riscv_pkg.sv
// Shared core definitions: fetch FSM states, datapath defaults and the
// major opcodes seen by the main decoder.
package riscv_pkg;

    localparam int          DEF_XLEN     = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } fetch_state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory req/gnt/rvalid port; master is the fetch stage.
interface fetch_unit_if
    import riscv_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [31:0]     rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/pc_next_sel.sv
// Next-PC select: sequential pc+4 (wraps modulo 2^XLEN) or redirect target.
module pc_next_sel #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);
    assign pc_plus4   = pc + XLEN'(4);
    assign next_pc    = redirect ? redirect_target : pc_plus4;
    assign misaligned = redirect && (redirect_target[1:0] != 2'b00);
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, holds the word until
// retire. Optional misaligned-target trap under FETCH_MISALIGN_TRAP_EN.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_unit_if.master     imem,
    output logic [31:0]      instr,
    output logic [6:0]       opcode,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_target
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic             fetch_fault
`endif
);
    fetch_state_t    state, state_n;
    logic [XLEN-1:0] pc_q, next_pc, pc_load;
    logic [31:0]     instr_q;
    logic            misaligned, retire;

    pc_next_sel #(.XLEN(XLEN)) u_pc_next_sel (
        .pc              (pc_q),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .pc_plus4        (pc_plus4),
        .next_pc         (next_pc),
        .misaligned      (misaligned)
    );

    assign retire = (state == HOLD) && instr_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
    // The faulting target is kept unmasked so the trap handler can see it.
    assign pc_load     = next_pc;
    assign fetch_fault = (state == FAULT);
`else
    logic [2:0] unused_bits;
    assign unused_bits = {misaligned, next_pc[1:0]};
    assign pc_load     = {next_pc[XLEN-1:2], 2'b00};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = REQ;
            REQ:  if (imem.gnt) state_n = WAIT;
            WAIT: if (imem.rvalid) state_n = HOLD;
            HOLD: begin
                if (instr_ready) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    state_n = misaligned ? FAULT : REQ;
`else
                    state_n = REQ;
`endif
                end
            end
            FAULT:   state_n = FAULT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            if (state == WAIT && imem.rvalid) instr_q <= imem.rdata;
            if (retire)                       pc_q    <= pc_load;
        end
    end

    assign imem.req    = (state == REQ);
    assign imem.addr   = pc_q;
    assign pc          = pc_q;
    assign instr_valid = (state == HOLD);
    // Zero when invalid so the decoder sees an opcode that writes nothing.
    assign instr       = instr_valid ? instr_q : 32'h0;
    assign opcode      = instr[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency, sequencing, redirect, stalls,
// mid-flight reset and misaligned targets (FETCH_MISALIGN_TRAP_EN aware).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr, pc, pc_plus4, redirect_target;
    logic [6:0]  opcode;
    logic        instr_valid, instr_ready, redirect;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_fault;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(32)) imem ();

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem            (imem),
        .instr           (instr),
        .opcode          (opcode),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .redirect        (redirect),
        .redirect_target (redirect_target)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_fault     (fetch_fault)
`endif
    );

    // Serve one fetch: gdly stall cycles before gnt, rdly before rvalid.
    task automatic do_fetch(input int gdly, input int rdly, input logic [31:0] data,
                            input logic [31:0] exp_addr, input bit imm, input string tag);
        int t = 0;
        while (imem.req !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (imem.req !== 1'b1 || (imm && t != 0)) begin
            errors++;
            $display("FAIL %s req_wait: req=%b after %0d cycles, need req=1 after %0d", tag, imem.req, t, 0);
        end
        checks++;
        if (imem.addr !== exp_addr) begin
            errors++;
            $display("FAIL %s addr: got %h want %h", tag, imem.addr, exp_addr);
        end
        for (int i = 0; i < gdly; i++) begin
            @(negedge clk);
            checks++;
            if (imem.req !== 1'b1 || imem.addr !== exp_addr || instr !== 32'h0 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s gnt_stall: req=%b addr=%h instr=%h valid=%b want 1 %h 0 0",
                         tag, imem.req, imem.addr, instr, instr_valid, exp_addr);
            end
        end
        imem.gnt = 1'b1;
        @(negedge clk);
        imem.gnt = 1'b0;
        for (int i = 0; i < rdly; i++) begin
            imem.gnt = 1'b1;
            @(negedge clk);
            imem.gnt = 1'b0;
            checks++;
            if (imem.req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0) begin
                errors++;
                $display("FAIL %s rvalid_stall: req=%b valid=%b instr=%h want 0 0 0",
                         tag, imem.req, instr_valid, instr);
            end
        end
        imem.rvalid = 1'b1;
        imem.rdata  = data;
        @(negedge clk);
        imem.rvalid = 1'b0;
        imem.rdata  = 32'hDEAD_BEEF;
        checks++;
        if (instr_valid !== 1'b1 || instr !== data || pc !== exp_addr || pc_plus4 !== exp_addr + 32'd4) begin
            errors++;
            $display("FAIL %s hold: valid=%b instr=%h pc=%h pc4=%h want 1 %h %h %h",
                     tag, instr_valid, instr, pc, pc_plus4, data, exp_addr, exp_addr + 32'd4);
        end
    endtask

    task automatic retire(input logic redir, input logic [31:0] tgt);
        instr_ready     = 1'b1;
        redirect        = redir;
        redirect_target = tgt;
        @(negedge clk);
        instr_ready     = 1'b0;
        redirect        = 1'b0;
        redirect_target = 32'h0000_0302;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        instr_ready = 1'b0;
        redirect = 1'b0;
        redirect_target = 32'h0;
        imem.gnt = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata = 32'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (imem.req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: req=%b valid=%b want 0 0", imem.req, instr_valid);
        end
        checks++;
        if (instr !== 32'h0 || opcode !== 7'h0) begin
            errors++;
            $display("FAIL reset_instr: instr=%h opcode=%h want 0 0", instr, opcode);
        end
        checks++;
        if (pc !== 32'h0 || imem.addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc: pc=%h addr=%h want 0 0", pc, imem.addr);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        checks++;
        if (fetch_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_fault: got %b want 0", fetch_fault);
        end
`endif
    endtask

    task automatic test_first_fetch;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h want 1 0", imem.req, imem.addr);
        end
        imem.gnt = 1'b1;
        @(negedge clk);
        imem.gnt = 1'b0;
        checks++;
        if (imem.req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0) begin
            errors++;
            $display("FAIL first_wait: req=%b valid=%b instr=%h want 0 0 0", imem.req, instr_valid, instr);
        end
        imem.rvalid = 1'b1;
        imem.rdata  = 32'h0050_0093;
        @(negedge clk);
        imem.rvalid = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || opcode !== 7'b0010011 || pc !== 32'h0 || instr !== 32'h0050_0093) begin
            errors++;
            $display("FAIL first_hold: valid=%b opcode=%b pc=%h instr=%h want 1 0010011 0 00500093",
                     instr_valid, opcode, pc, instr);
        end
    endtask

    task automatic test_sequential;
        retire(1'b0, 32'h0);
        do_fetch(0, 0, 32'h0010_0113, 32'h4, 1'b1, "seq1");
        retire(1'b0, 32'h0);
        do_fetch(0, 0, 32'h0020_0193, 32'h8, 1'b1, "seq2");
        retire(1'b0, 32'h0);
        do_fetch(0, 0, 32'h0030_0213, 32'hC, 1'b1, "seq3");
    endtask

    task automatic test_redirect;
        retire(1'b1, 32'h0000_0100);
        // Redirect held through REQ/WAIT must not move the pc.
        redirect = 1'b1;
        redirect_target = 32'h0000_0300;
        do_fetch(0, 0, 32'h0000_006F, 32'h100, 1'b1, "redir");
        redirect = 1'b0;
        retire(1'b0, 32'h0);
        do_fetch(0, 0, 32'h0000_0013, 32'h104, 1'b1, "redir_ignored");
        retire(1'b1, 32'hFFFF_FFFC);
        do_fetch(0, 0, 32'h0000_0063, 32'hFFFF_FFFC, 1'b1, "top_addr");
        retire(1'b0, 32'h0);
        do_fetch(0, 0, 32'h0000_0033, 32'h0, 1'b1, "wrap");
    endtask

    task automatic test_stall;
        for (int i = 0; i < 4; i++) begin
            imem.rvalid = 1'b1;
            imem.rdata  = 32'hFFFF_FFFF;
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || instr !== 32'h0000_0033 || pc !== 32'h0 || imem.req !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable: valid=%b instr=%h pc=%h req=%b want 1 00000033 0 0",
                         instr_valid, instr, pc, imem.req);
            end
        end
        imem.rvalid = 1'b0;
        retire(1'b0, 32'h0);
        do_fetch(5, 3, 32'h0040_0293, 32'h4, 1'b1, "stall");
    endtask

    task automatic test_reset_mid;
        retire(1'b0, 32'h0);
        checks++;
        if (imem.req !== 1'b1 || imem.addr !== 32'h8) begin
            errors++;
            $display("FAIL mid_req: req=%b addr=%h want 1 8", imem.req, imem.addr);
        end
        imem.gnt = 1'b1;
        @(negedge clk);
        imem.gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem.req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0 || instr !== 32'h0) begin
            errors++;
            $display("FAIL mid_async: req=%b valid=%b pc=%h instr=%h want 0 0 0 0",
                     imem.req, instr_valid, pc, instr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        imem.rvalid = 1'b1;
        imem.rdata  = 32'hBAD0_0BAD;
        @(negedge clk);
        imem.rvalid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || imem.req !== 1'b1 || instr !== 32'h0) begin
            errors++;
            $display("FAIL stale_drop: valid=%b req=%b instr=%h want 0 1 0", instr_valid, imem.req, instr);
        end
        do_fetch(0, 0, 32'h00A0_0193, 32'h0, 1'b1, "after_reset");
    endtask

    task automatic test_misalign;
        retire(1'b1, 32'h0000_0102);
`ifdef FETCH_MISALIGN_TRAP_EN
        checks++;
        if (fetch_fault !== 1'b1 || imem.req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h102) begin
            errors++;
            $display("FAIL fault_entry: fault=%b req=%b valid=%b pc=%h want 1 0 0 102",
                     fetch_fault, imem.req, instr_valid, pc);
        end
        for (int i = 0; i < 4; i++) begin
            imem.gnt = 1'b1;
            imem.rvalid = 1'b1;
            @(negedge clk);
            checks++;
            if (fetch_fault !== 1'b1 || imem.req !== 1'b0 || instr !== 32'h0) begin
                errors++;
                $display("FAIL fault_sticky: fault=%b req=%b instr=%h want 1 0 0", fetch_fault, imem.req, instr);
            end
        end
        imem.gnt = 1'b0;
        imem.rvalid = 1'b0;
`else
        do_fetch(0, 0, 32'h0000_0013, 32'h100, 1'b1, "misalign_masked");
`endif
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_sequential();
        test_redirect();
        test_stall();
        test_reset_mid();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded 200000 time units");
        $fatal(1);
    end

endmodule
